// File: rtl/conv_bram_pkg.sv
// ---------------------------------------------------------------------------
// conv_bram_pkg
// Shared types and constants for the membrane-potential read-modify-write
// controller of the convolution stage.
//   DATA_W / ADDR_W : default word and address widths of the membrane RAM.
//   SAT_MAX/SAT_MIN : saturation bounds of a signed DATA_W word.
//   rmw_state_t     : controller mode (RUN, DRAIN, CLEAR).
//   stage_t         : one pipeline stage record {valid, addr, value}.
// ---------------------------------------------------------------------------
package conv_bram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } rmw_state_t;

    typedef struct packed {
        logic                     valid;
        logic [ADDR_W-1:0]        addr;
        logic signed [DATA_W-1:0] value;
    } stage_t;

endpackage

// File: rtl/sat_add_thresh.sv
// ---------------------------------------------------------------------------
// sat_add_thresh
// Combinational saturating add of a membrane word and a signed delta,
// followed by the firing-threshold compare.
//   base      in  : current membrane potential (signed)
//   delta     in  : signed increment
//   threshold in  : signed firing threshold
//   value     out : word to store (0 after a spike, else the saturated sum)
//   spike     out : saturated sum reached the threshold
// ---------------------------------------------------------------------------
module sat_add_thresh
    import conv_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic signed [DATA_WIDTH-1:0] base,
    input  logic signed [DATA_WIDTH-1:0] delta,
    input  logic signed [DATA_WIDTH-1:0] threshold,
    output logic signed [DATA_WIDTH-1:0] value,
    output logic                         spike
);

    logic signed [DATA_WIDTH:0]   sum;
    logic signed [DATA_WIDTH-1:0] sat_sum;

    always_comb begin
        // One guard bit is enough for the sum of two signed words; the two
        // top bits disagree exactly when the true result left the word range.
        sum = {base[DATA_WIDTH-1], base} + {delta[DATA_WIDTH-1], delta};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            sat_sum = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_sum = sum[DATA_WIDTH-1:0];
        end
        spike = (sat_sum >= threshold);
        value = spike ? '0 : sat_sum;
    end

endmodule

// File: rtl/membrane_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// membrane_rmw_ctrl
// Owns both ports of the dual-port membrane RAM. Each accepted request reads
// the word on port A, adds the delta with saturation, compares against the
// threshold and writes the result back on port B two cycles later. Results
// still in flight are forwarded so back-to-back updates of one neuron see
// each other. A clear pulse drains the pipeline and then zeroes every word.
//
// Ports
//   clk, rst_n                 : clock (shared with the RAM), async reset
//   req_valid/req_ready        : request handshake
//   req_addr, req_delta        : neuron address and signed increment
//   cfg_threshold              : firing threshold, used in the S1 cycle
//   clear_start / clear_done   : start pulse / completion pulse of the sweep
//   out_valid/out_addr/out_spike : per-request result (no backpressure)
//   en_a, we_a, addr_a, data_out_a : RAM port A (read only, 1-cycle latency)
//   en_b, we_b, addr_b, data_in_b  : RAM port B (write only)
//
// The stage records use the package widths, so DATA_WIDTH and ADDR_WIDTH
// must stay equal to conv_bram_pkg::DATA_W / ADDR_W.
// ---------------------------------------------------------------------------
module membrane_rmw_ctrl
    import conv_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic signed [DATA_WIDTH-1:0] req_delta,
    input  logic signed [DATA_WIDTH-1:0] cfg_threshold,
    input  logic                         clear_start,
    output logic                         clear_done,
    output logic                         out_valid,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         out_spike,
    output logic                         en_a,
    output logic                         we_a,
    output logic [ADDR_WIDTH-1:0]        addr_a,
    input  logic [DATA_WIDTH-1:0]        data_out_a,
    output logic                         en_b,
    output logic                         we_b,
    output logic [ADDR_WIDTH-1:0]        addr_b,
    output logic [DATA_WIDTH-1:0]        data_in_b
);

    rmw_state_t state, state_next;

    logic ready_q;
    logic done_q;
    logic accept;
    logic in_clear;
    logic clr_last;

    logic [ADDR_WIDTH-1:0] clr_addr;

    // S1: request whose RAM read is returning this cycle.
    logic                         s1_valid;
    logic [ADDR_WIDTH-1:0]        s1_addr;
    logic signed [DATA_WIDTH-1:0] s1_delta;

    // S2: word being written now; S3: word written in the previous cycle,
    // kept because the RAM read issued alongside that write saw old data.
    stage_t s2;
    stage_t s3;
    logic   s2_spike;

    logic signed [DATA_WIDTH-1:0] base;
    logic signed [DATA_WIDTH-1:0] wr_value;
    logic                         spike;

    assign accept   = req_valid && ready_q;
    assign in_clear = (state == CLEAR);
    assign clr_last = (clr_addr == '1);

    // ------------------------------------------------------------------
    // Mode control
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            RUN:     if (clear_start) state_next = DRAIN;
            // S3 empties on the same edge that S2 does, so S1/S2 empty is
            // enough to know all three stages are empty in the next cycle.
            DRAIN:   if (!s1_valid && !s2.valid) state_next = CLEAR;
            CLEAR:   if (clr_last) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Base selection: youngest in-flight write to the same address wins.
    // ------------------------------------------------------------------
    always_comb begin
        base = $signed(data_out_a);
        if (s2.valid && (s2.addr == s1_addr)) begin
            base = s2.value;
        end else if (s3.valid && (s3.addr == s1_addr)) begin
            base = s3.value;
        end
    end

    sat_add_thresh #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_add_thresh (
        .base      (base),
        .delta     (s1_delta),
        .threshold (cfg_threshold),
        .value     (wr_value),
        .spike     (spike)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            clr_addr <= '0;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_delta <= '0;
            s2       <= '0;
            s2_spike <= 1'b0;
            s3       <= '0;
        end else begin
            state    <= state_next;
            // Registered so it drops the cycle after clear_start and stays
            // low during reset.
            ready_q  <= (state_next == RUN);
            done_q   <= in_clear && clr_last;
            clr_addr <= in_clear ? clr_addr + ADDR_WIDTH'(1) : '0;

            s1_valid <= accept;
            s1_addr  <= req_addr;
            s1_delta <= req_delta;

            s2.valid <= s1_valid;
            s2.addr  <= s1_addr;
            s2.value <= wr_value;
            s2_spike <= spike;

            s3       <= s2;
            if (in_clear && clr_last) begin
                s3.valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = ready_q;
    assign clear_done = done_q;

    assign en_a   = accept;
    assign we_a   = 1'b0;
    assign addr_a = accept ? req_addr : '0;

    // S2 is always empty during the sweep, so the two writers never collide.
    assign en_b      = in_clear || s2.valid;
    assign we_b      = in_clear || s2.valid;
    assign addr_b    = in_clear ? clr_addr : s2.addr;
    assign data_in_b = in_clear ? '0 : s2.value;

    assign out_valid = s2.valid;
    assign out_addr  = s2.addr;
    assign out_spike = s2.valid && s2_spike;

endmodule

// File: doc/membrane_rmw_ctrl.md
# membrane_rmw_ctrl

Read-modify-write controller that owns both ports of the convolution stage's dual-port block RAM holding membrane potentials. Accepts one accumulate request per cycle (address, signed delta) and reads via port A. It adds with saturation and compares against a threshold, then writes back via port B. Includes forwarding for back-to-back same-address updates, and a full-memory clear sweep.

## Interface
- DATA_WIDTH, 16: signed membrane word width; must equal the RAM word width.
- ADDR_WIDTH, 11: RAM address width; depth 2**ADDR_WIDTH.
- Clock/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  accumulate request valid.
- req_ready  out  1  controller can accept; transfer when valid&&ready.
- req_addr  in  ADDR_WIDTH  neuron address.
- req_delta  in  DATA_WIDTH  signed increment.
- cfg_threshold  in  DATA_WIDTH  signed firing threshold; sampled per request at S1.
- clear_start  in  1  one-cycle pulse: zero the whole RAM.
- clear_done  out  1  one-cycle pulse when the sweep finishes.
- out_valid  out  1  result pulse, no backpressure.
- out_addr  out  ADDR_WIDTH  address of the result.
- out_spike  out  1  threshold crossed; stored value was reset to 0.
- en_a, we_a  out  1 each  RAM port A enable/write; we_a is constant 0.
- addr_a  out  ADDR_WIDTH  port A read address.
- data_out_a  in  DATA_WIDTH  port A read data, 1-cycle registered latency.
- en_b, we_b  out  1 each  RAM port B enable/write.
- addr_b  out  ADDR_WIDTH  port B write address.
- data_in_b  out  DATA_WIDTH  port B write data.

## Operation
- States: RUN, DRAIN, CLEAR. Reset enters RUN.
- All registered outputs reset to 0, and all pipeline valids reset to 0.
- req_ready is 1 only in RUN with no pending clear.
- Pipeline, per request:
  - S0 (accept cycle): en_a=1, addr_a=req_addr.
  - S1: computes the result from base + delta.
  - S2: drives port B (en_b=we_b=1), and drives out_valid/out_addr/out_spike.
  - S3: holds the last written addr/value for one more cycle.
- Base selection in S1, in priority order:
  - S2 value, if S2 is valid and addr1==addr2.
  - Else S3 value, if S3 is valid and addr1==addr3.
  - Else data_out_a.
  - The resulting port A/B same-address overlap is a known, forwarded case and is not an error.
- Arithmetic:
  - Sum is computed in DATA_WIDTH+1 bits, then clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If sat_sum >= cfg_threshold (signed), spike=1 and the written value is 0.
  - Otherwise spike=0 and the written value is sat_sum.
- Clear handling:
  - clear_start in RUN latches a pending clear, drops req_ready, and moves to DRAIN.
  - DRAIN lasts until S1/S2/S3 are empty.
  - CLEAR writes 0 via port B at addresses 0..2**ADDR_WIDTH-1, one per cycle, with port A idle.
  - After the last address: pulse clear_done, invalidate S3, return to RUN.
- clear_start while in DRAIN/CLEAR: ignored.
- clear_start in the same cycle as a request handshake: req_ready was already 1, so the request is accepted and drains normally before the sweep.
- Reset mid-sweep or mid-pipeline: all state is abandoned, and RAM contents are undefined for in-flight words.

## Timing
- Request accepted at cycle t:
  - RAM read at edge t.
  - S1 at t+1.
  - Write and out_valid at t+2; the RAM is updated at edge t+2.
- Throughput: 1 request/cycle in RUN, with no bubbles for any address pattern.
- req_ready falls the cycle after clear_start.
- Clear total: drain (≤3 cycles) + 2**ADDR_WIDTH write cycles.
- clear_done asserts in the cycle after the final write.

## Structure
- Package conv_bram_pkg holds:
  - state enum rmw_state_t {RUN, DRAIN, CLEAR}.
  - stage struct {valid, addr, value}.
  - saturation-bound constants derived from DATA_WIDTH.
- One natural sub-module, sat_add_thresh: a combinational saturating add plus threshold compare that returns {value, spike}.
- The bench pairs this block with the existing dual-port RAM model.

## Test plan
- Reset, then three requests to distinct addresses 1,2,3, delta=5, threshold=100 -> out_valid at t+2..t+4, RAM[1..3]=5, out_spike=0.
- Four back-to-back requests to addr 7, delta=+10 -> written values 10,20,30,40, exercising S2 and S3 forwarding; a request to addr 7 two cycles later reads 40 and writes 50.
- Addr 9 preloaded to 32760, delta=+100, threshold=32767 -> clamped to 32767 ≥ threshold, so out_spike=1 and RAM[9]=0; RAM[10]=-32760 with delta=-100 -> RAM[10]=-32768, no spike.
- Threshold=25, repeated +10 to addr 4 -> spike on the third update, RAM[4]=0, fourth update writes 10.
- clear_start with 2 requests in flight -> both complete, then 2048 zero writes; clear_done fires; req_ready stays 0 throughout; all RAM words read 0.
- rst_n asserted mid-sweep -> all outputs 0 immediately; after release, state RUN and req_ready=1 on the first edge.
